// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR stream generator family.
// Functions take 32-bit operands and a width so one copy serves every instance size.
package lfsr_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } lfsr_fsm_e;

    // Maximal-length Fibonacci tap masks for the commonly used widths.
    function automatic logic [31:0] default_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            4:       taps = 32'h0000_000C;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0]  s,
                                              input logic [31:0]  taps,
                                              input int unsigned  width);
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = ^(s & taps & mask);
        return ((s << 1) | {31'd0, fb}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational single-step Fibonacci LFSR successor: shift left, feedback into bit 0.
module lfsr_next_state
    import lfsr_pkg::*;
#(
    parameter int unsigned            WIDTH = 4,
    parameter logic [WIDTH-1:0]       TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    always_comb begin
        next_state = WIDTH'(lfsr_next(32'(state), 32'(TAPS), WIDTH));
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// Seed-loadable LFSR word source with valid/ready output, zero-seed and lock-up
// protection, and measurement of the sequence length seen on the output.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH        = 4,
    parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = 4'b0001
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             en,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_bit,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    output logic             seed_err,
    output logic             lock_err
);

    lfsr_fsm_e        fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_reg_q, seed_reg_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             seed_err_q, seed_err_d;
    logic             lock_err_q, lock_err_d;

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_eff;
    logic             advance;

    lfsr_next_state #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state      (state_q),
        .next_state (next_state)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= StIdle;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state: only reset leaves RUN
    always_comb begin
        fsm_d = fsm_q;
        if (load) begin
            fsm_d = StRun;
        end
    end

    // FSM outputs
    always_comb begin
        out_valid = (fsm_q == StRun) && en;
    end

    assign advance  = out_valid && out_ready;
    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

    always_comb begin
        state_d        = state_q;
        seed_reg_d     = seed_reg_q;
        cnt_d          = cnt_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        seed_err_d     = 1'b0;
        lock_err_d     = lock_err_q;
        if (load) begin
            // The word on the output in the load cycle is discarded, not consumed.
            state_d    = seed_eff;
            seed_reg_d = seed_eff;
            cnt_d      = '0;
            lock_err_d = 1'b0;
            seed_err_d = (seed == '0);
        end else if (advance) begin
            if (next_state == '0) begin
                state_d    = DEFAULT_SEED;
                seed_reg_d = DEFAULT_SEED;
                cnt_d      = '0;
                lock_err_d = 1'b1;
            end else begin
                state_d = next_state;
                if (cnt_q != '1) begin
                    if (next_state == seed_reg_q) begin
                        period_d       = cnt_q + WIDTH'(1);
                        period_valid_d = 1'b1;
                        cnt_d          = '0;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= '0;
            seed_reg_q     <= '0;
            cnt_q          <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            seed_err_q     <= 1'b0;
            lock_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            seed_reg_q     <= seed_reg_d;
            cnt_q          <= cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            seed_err_q     <= seed_err_d;
            lock_err_q     <= lock_err_d;
        end
    end

    assign out_data     = state_q;
    assign out_bit      = state_q[WIDTH-1];
    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign seed_err     = seed_err_q;
    assign lock_err     = lock_err_q;

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Bench for lfsr_stream_gen: table-driven sequence, hand-written corner cases,
// randomized flow control against a word-level reference model, and a lock-up instance.
module tb_lfsr_stream_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] seed;
    logic       en;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_bit;
    logic [3:0] period;
    logic       period_valid;
    logic       seed_err;
    logic       lock_err;

    logic       l_load;
    logic [3:0] l_seed;
    logic       l_ready;
    logic       l_valid;
    logic [3:0] l_data;
    logic       l_bit;
    logic [3:0] l_period;
    logic       l_pv;
    logic       l_serr;
    logic       l_lock;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    lfsr_stream_gen #(
        .WIDTH        (4),
        .TAPS         (4'b1100),
        .DEFAULT_SEED (4'b0001)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .seed         (seed),
        .en           (en),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_bit      (out_bit),
        .period       (period),
        .period_valid (period_valid),
        .seed_err     (seed_err),
        .lock_err     (lock_err)
    );

    // Degenerate taps: every seed shifts out to zero, exercising lock-up recovery.
    lfsr_stream_gen #(
        .WIDTH        (4),
        .TAPS         (4'b0000),
        .DEFAULT_SEED (4'b0001)
    ) dut_lock (
        .clk          (clk),
        .reset        (reset),
        .load         (l_load),
        .seed         (l_seed),
        .en           (1'b1),
        .out_ready    (l_ready),
        .out_valid    (l_valid),
        .out_data     (l_data),
        .out_bit      (l_bit),
        .period       (l_period),
        .period_valid (l_pv),
        .seed_err     (l_serr),
        .lock_err     (l_lock)
    );

    // Reference model: word-level view of the stream.
    bit       m_run;
    int       m_word;
    int       m_seed;
    int       m_count;
    int       m_period;
    bit       m_pv;
    bit       m_serr;
    bit       m_lock;

    function automatic int ref_next(input int s);
        int ones;
        ones = 0;
        // x^4 + x^3 + 1: feedback is parity of bits 3 and 2
        if ((s / 8) % 2 == 1) ones++;
        if ((s / 4) % 2 == 1) ones++;
        return (s * 2) % 16 + ones % 2;
    endfunction

    task automatic model_reset();
        m_run = 0; m_word = 0; m_seed = 0; m_count = 0;
        m_period = 0; m_pv = 0; m_serr = 0; m_lock = 0;
    endtask

    task automatic model_step(input logic ld, input logic [3:0] sd, input logic e,
                              input logic r);
        int nx;
        m_pv   = 0;
        m_serr = 0;
        if (ld) begin
            m_word  = (sd == 0) ? 1 : int'(sd);
            m_seed  = m_word;
            m_count = 0;
            m_lock  = 0;
            m_serr  = (sd == 0);
            m_run   = 1;
        end else if (m_run && e && r) begin
            nx = ref_next(m_word);
            if (nx == 0) begin
                m_word = 1; m_seed = 1; m_count = 0; m_lock = 1;
            end else begin
                m_word = nx;
                if (m_count < 15) begin
                    m_count++;
                    if (nx == m_seed) begin
                        m_period = m_count;
                        m_count  = 0;
                        m_pv     = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".data"},   32'(out_data),     32'(m_word));
        chk({tag, ".valid"},  32'(out_valid),    32'(m_run && en));
        chk({tag, ".bit"},    32'(out_bit),      32'((m_word / 8) % 2));
        chk({tag, ".period"}, 32'(period),       32'(m_period));
        chk({tag, ".pv"},     32'(period_valid), 32'(m_pv));
        chk({tag, ".serr"},   32'(seed_err),     32'(m_serr));
        chk({tag, ".lock"},   32'(lock_err),     32'(m_lock));
    endtask

    // Apply one cycle of inputs, then compare at the following falling edge.
    task automatic step(input logic ld, input logic [3:0] sd, input logic e, input logic r);
        model_step(ld, sd, e, r);
        load = ld; seed = sd; en = e; out_ready = r;
        @(negedge clk);
    endtask

    task automatic lstep(input logic ld, input logic [3:0] sd, input logic r);
        l_load = ld; l_seed = sd; l_ready = r;
        @(negedge clk);
    endtask

    typedef struct {
        logic       ld;
        logic [3:0] sd;
        logic       e;
        logic       r;
        logic [3:0] d;
        logic       v;
        logic       pv;
        logic [3:0] per;
    } vec_t;

    vec_t       tbl[17];
    logic [3:0] seq[16];
    int         pv_seen;

    initial begin
        reset = 1'b1; load = 1'b1; seed = 4'h5; en = 1'b1; out_ready = 1'b1;
        l_load = 1'b1; l_seed = 4'h3; l_ready = 1'b1;
        model_reset();

        // Reset held two cycles with load asserted: reset wins
        repeat (2) @(negedge clk);
        chk("rst.data",   32'(out_data),     32'h0);
        chk("rst.valid",  32'(out_valid),    32'h0);
        chk("rst.bit",    32'(out_bit),      32'h0);
        chk("rst.period", 32'(period),       32'h0);
        chk("rst.pv",     32'(period_valid), 32'h0);
        chk("rst.serr",   32'(seed_err),     32'h0);
        chk("rst.lock",   32'(lock_err),     32'h0);
        chk("rst.lvalid", 32'(l_valid),      32'h0);
        reset = 1'b0; l_load = 1'b0;

        // IDLE ignores en/out_ready
        step(1'b0, 4'h0, 1'b1, 1'b1);
        chk_model("idle");

        seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
        tbl[0] = '{1'b1, 4'h1, 1'b1, 1'b0, 4'h1, 1'b1, 1'b0, 4'h0};
        for (int i = 1; i < 16; i++) begin
            tbl[i] = '{1'b0, 4'h0, 1'b1, 1'b1, seq[i], 1'b1, (i == 15), (i == 15) ? 4'hF : 4'h0};
        end
        tbl[16] = '{1'b0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b1, 1'b0, 4'hF};
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].ld, tbl[i].sd, tbl[i].e, tbl[i].r);
            chk($sformatf("seq[%0d].data", i),   32'(out_data),     32'(tbl[i].d));
            chk($sformatf("seq[%0d].valid", i),  32'(out_valid),    32'(tbl[i].v));
            chk($sformatf("seq[%0d].pv", i),     32'(period_valid), 32'(tbl[i].pv));
            chk($sformatf("seq[%0d].period", i), 32'(period),       32'(tbl[i].per));
        end

        // Zero seed replaced by the default and flagged for one cycle
        step(1'b1, 4'h0, 1'b1, 1'b0);
        chk("zseed.data", 32'(out_data), 32'h1);
        chk("zseed.serr", 32'(seed_err), 32'h1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("zseed.data2", 32'(out_data), 32'h1);
        chk("zseed.serr2", 32'(seed_err), 32'h0);
        chk_model("zseed");

        // Load beats a simultaneous handshake; count restarts from the new seed
        step(1'b0, 4'h0, 1'b1, 1'b1);
        chk("prio.pre", 32'(out_data), 32'h2);
        step(1'b1, 4'h9, 1'b1, 1'b1);
        chk("prio.data", 32'(out_data), 32'h9);
        chk_model("prio");
        pv_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 4'h0, 1'b1, 1'b1);
            chk_model("prio.run");
            if (period_valid) pv_seen++;
        end
        chk("prio.pv_last", 32'(period_valid), 32'h1);
        chk("prio.pv_count", 32'(pv_seen), 32'h1);
        chk("prio.period", 32'(period), 32'hF);
        chk("prio.wrap", 32'(out_data), 32'h9);

        // Random backpressure, enable gaps and occasional (possibly zero) reloads
        step(1'b1, 4'h1, 1'b1, 1'b1);
        chk_model("bp.load");
        for (int i = 0; i < 400; i++) begin
            logic       ld;
            logic [3:0] sd;
            ld = ($urandom_range(0, 59) == 0);
            sd = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            step(ld, sd, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            chk_model($sformatf("bp[%0d]", i));
        end

        // Lock-up recovery with all-zero taps
        lstep(1'b1, 4'h8, 1'b1);
        chk("lock.load", 32'(l_data), 32'h8);
        chk("lock.clr",  32'(l_lock), 32'h0);
        lstep(1'b0, 4'h0, 1'b0);
        chk("lock.stall", 32'(l_data), 32'h8);
        chk("lock.stall_flag", 32'(l_lock), 32'h0);
        lstep(1'b0, 4'h0, 1'b1);
        chk("lock.recover", 32'(l_data), 32'h1);
        chk("lock.set", 32'(l_lock), 32'h1);
        lstep(1'b0, 4'h0, 1'b1);
        chk("lock.adv", 32'(l_data), 32'h2);
        chk("lock.sticky", 32'(l_lock), 32'h1);
        lstep(1'b1, 4'h5, 1'b0);
        chk("lock.reload", 32'(l_data), 32'h5);
        chk("lock.cleared", 32'(l_lock), 32'h0);
        chk("lock.pv", 32'(l_pv), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
